rename_map_unit: RTL and testbench
==================================

Name: rename_map_unit

Overview:
- Parametrised, multi-lane register renaming unit for the Tomasulo core; successor to the single-port RegisterRenaming block.
- Holds a speculative map table (RAT), a retirement map table (RRAT) and a circular free list of physical registers.
- Renames up to WIDTH instructions per cycle and retires up to CWIDTH per cycle.
- Adds intra-group dependency bypass, x0 handling, and single-cycle flush recovery to the committed state.

Parameters:
- ARCH_REGS, 32, number of architectural registers; arch reg 0 is hard zero.
- PHYS_REGS, 64, number of physical registers; PHYS_REGS-ARCH_REGS must be a power of two.
- WIDTH, 2, rename lanes per cycle.
- CWIDTH, 2, commit lanes per cycle.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rename_valid  in  WIDTH  per-lane rename request.
- rename_src1, rename_src2  in  WIDTH x ARCH_REG  source arch regs.
- rename_dest  in  WIDTH x ARCH_REG  destination arch reg; 0 = no destination.
- rename_ready  out  1  high when free_count >= WIDTH.
- phys_src1, phys_src2  out  WIDTH x PHYS_REG  renamed source tags (combinational).
- phys_dest  out  WIDTH x PHYS_REG  newly allocated tag; 0 when dest is 0.
- phys_old_dest  out  WIDTH x PHYS_REG  prior mapping of dest, carried to ROB for commit.
- commit_valid  in  CWIDTH  per-lane commit, in program order, lane 0 oldest.
- commit_arch  in  CWIDTH x ARCH_REG  committed dest arch reg.
- commit_phys  in  CWIDTH x PHYS_REG  committed dest phys tag.
- flush  in  1  mispredict/exception recovery.
- free_count  out  clog2(PHYS_REGS-ARCH_REGS)+1  registered free-list occupancy.

Behaviour:
- Reset (asynchronous):
  - RAT[i] = RRAT[i] = i.
  - Free list slots 0..FL-1 = ARCH_REGS..PHYS_REGS-1, where FL = PHYS_REGS-ARCH_REGS.
  - head = 0, retire_head = 0, tail = FL (pointers one bit wider than the index); free_count = FL.
  - rename_ready = 1 for defaults.
- Rename outputs (combinational, zero latency):
  - Read from the registered RAT.
  - Lane i sources and old_dest are bypassed from the youngest earlier lane j<i whose valid dest matches; that lane's phys_dest is used.
  - Source 0 always yields tag 0.
- Allocation:
  - Each valid lane with dest != 0 pops the next free-list entry in lane order.
  - Takes effect when rename_ready && any rename_valid.
  - RAT is written at the edge; the later lane wins on a same-dest conflict.
  - If rename_ready = 0, no state changes and outputs are don't-care.
- Commit, lanes processed in order within a cycle:
  - For commit_arch != 0: freed tag = RRAT value as updated by earlier lanes of the same cycle.
  - The freed tag is pushed at tail, RRAT[arch] <= commit_phys, and retire_head advances by 1.
  - commit_arch = 0 is ignored.
- Simultaneous rename and commit: pops use the registered count, so entries pushed this cycle are visible next cycle. free_count_next = free_count - pops + pushes.
- Flush:
  - RAT <= RRAT including the same cycle's commits.
  - head <= retire_head advanced by the same cycle's commits.
  - Same-cycle rename is dropped.
  - Commits in the flush cycle are still performed.
- Overflow/underflow are impossible by construction. An assertion fires if free_count exceeds FL or a pop occurs at 0.
- Pointer wrap is modulo FL; the extra MSB distinguishes full from empty.

Decomposition:
- Package rename_pkg, shared with ROB and reservation stations: ARCH_REG and PHYS_REG typedefs, the ARCH_REGS/PHYS_REGS defaults, and the ZERO_REG constant.
- Sub-module rename_free_list:
  - Contains the circular buffer and the head, tail and retire_head pointers.
  - Handles multi-pop, multi-push and flush restore.
  - Reports count.
- The top level contains the RAT, RRAT and bypass logic.

Test Plan:
1. Reset, then lanes {dest5,src5} and {dest7,src1=5} -> lane0 src1=5, dest=32, old=5; lane1 src1=32 (bypass), dest=33, old=7; free_count=30.
2. Lane0 dest=0, lane1 dest=3 -> lane0 phys_dest=0, lane1 gets 32; free_count=31; RAT[0] still 0.
3. Sixteen cycles of two allocations -> free_count=0, rename_ready=0. Commit x5/phys32 -> free_count=1, ready stays 0. Second commit -> free_count=2, ready=1.
4. Allocate 32(x5), 33(x7), 34(x9); commit x5/32; then flush -> RAT[5]=32, RAT[7]=7, RAT[9]=9; free_count=32; next allocations return 33, 34.
5. Same-cycle commits x4/32 then x4/33 after two renames of x4 -> frees 4 then 32; RRAT[4]=33.
6. Assert reset mid-burst with free_count=10 -> immediately RAT identity, free_count=32, next allocation returns 32.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared renaming types and defaults, imported by the rename unit, ROB and reservation stations.
package rename_pkg;

  localparam int DEF_ARCH_REGS = 32;
  localparam int DEF_PHYS_REGS = 64;

  typedef logic [$clog2(DEF_ARCH_REGS)-1:0] arch_reg_t;
  typedef logic [$clog2(DEF_PHYS_REGS)-1:0] phys_reg_t;

  // Architectural register 0 is hard-wired zero and always maps to physical tag 0.
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/rename_map_unit_if.sv
// Rename/commit/flush bundle between the core front end (master) and the rename map unit (slave).
interface rename_map_unit_if
  import rename_pkg::*;
#(
  parameter int ARCH_REGS = DEF_ARCH_REGS,
  parameter int PHYS_REGS = DEF_PHYS_REGS,
  parameter int WIDTH     = 2,
  parameter int CWIDTH    = 2
);
  localparam int AW = $clog2(ARCH_REGS);
  localparam int PW = $clog2(PHYS_REGS);
  localparam int CW = $clog2(PHYS_REGS - ARCH_REGS) + 1;

  logic [WIDTH-1:0]          rename_valid;
  logic [WIDTH-1:0][AW-1:0]  rename_src1;
  logic [WIDTH-1:0][AW-1:0]  rename_src2;
  logic [WIDTH-1:0][AW-1:0]  rename_dest;
  logic                      rename_ready;
  logic [WIDTH-1:0][PW-1:0]  phys_src1;
  logic [WIDTH-1:0][PW-1:0]  phys_src2;
  logic [WIDTH-1:0][PW-1:0]  phys_dest;
  logic [WIDTH-1:0][PW-1:0]  phys_old_dest;
  logic [CWIDTH-1:0]         commit_valid;
  logic [CWIDTH-1:0][AW-1:0] commit_arch;
  logic [CWIDTH-1:0][PW-1:0] commit_phys;
  logic                      flush;
  logic [CW-1:0]             free_count;

  modport master (
    output rename_valid, rename_src1, rename_src2, rename_dest,
    output commit_valid, commit_arch, commit_phys, flush,
    input  rename_ready, phys_src1, phys_src2, phys_dest, phys_old_dest, free_count
  );

  modport slave (
    input  rename_valid, rename_src1, rename_src2, rename_dest,
    input  commit_valid, commit_arch, commit_phys, flush,
    output rename_ready, phys_src1, phys_src2, phys_dest, phys_old_dest, free_count
  );

endinterface

// File: rtl/rename_free_list.sv
// Circular free list of physical tags: multi-pop at head, multi-push at tail, and
// retire_head tracking the committed boundary so a flush can rewind head in one cycle.
module rename_free_list
  import rename_pkg::*;
#(
  parameter int ARCH_REGS = DEF_ARCH_REGS,
  parameter int PHYS_REGS = DEF_PHYS_REGS,
  parameter int WIDTH     = 2,
  parameter int CWIDTH    = 2
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [$clog2(PHYS_REGS-ARCH_REGS):0]        pop_cnt,
  output logic [WIDTH-1:0][$clog2(PHYS_REGS)-1:0]     pop_tags,
  input  logic [CWIDTH-1:0]                           push_valid,
  input  logic [CWIDTH-1:0][$clog2(PHYS_REGS)-1:0]    push_tags,
  input  logic                                        flush,
  output logic [$clog2(PHYS_REGS-ARCH_REGS):0]        count
);
  localparam int FL   = PHYS_REGS - ARCH_REGS;
  localparam int IW   = $clog2(FL);
  localparam int PTRW = IW + 1;
  localparam int PW   = $clog2(PHYS_REGS);

  logic [PW-1:0]   mem_q [FL];
  logic [PTRW-1:0] head_q, tail_q, rhead_q;
  logic [PTRW-1:0] head_d, tail_d, rhead_d;
  logic [PTRW-1:0] count_q;
  logic [CWIDTH-1:0][IW-1:0] push_idx;

  // Speculative pops are read straight off the head; only pop_cnt of them are consumed.
  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      pop_tags[k] = mem_q[head_q[IW-1:0] + IW'(k)];
    end
  end

  // Every non-zero commit frees exactly one tag and retires exactly one allocation, so
  // tail and retire_head move together and tail - retire_head stays at FL.
  always_comb begin
    int n;
    n = 0;
    for (int k = 0; k < CWIDTH; k++) begin
      push_idx[k] = tail_q[IW-1:0] + IW'(n);
      if (push_valid[k]) n++;
    end
    tail_d  = tail_q + PTRW'(n);
    rhead_d = rhead_q + PTRW'(n);
    head_d  = flush ? rhead_d : head_q + PTRW'(pop_cnt);
  end

  // NOTE: the buffer contents are architectural (they seed the initial free tags), so
  // unlike a plain storage RAM this memory must be reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FL; i++) mem_q[i] <= PW'(ARCH_REGS + i);
      head_q  <= '0;
      rhead_q <= '0;
      tail_q  <= PTRW'(FL);
      count_q <= PTRW'(FL);
    end else begin
      for (int k = 0; k < CWIDTH; k++) begin
        if (push_valid[k]) mem_q[push_idx[k]] <= push_tags[k];
      end
      head_q  <= head_d;
      rhead_q <= rhead_d;
      tail_q  <= tail_d;
      count_q <= tail_d - head_d;
    end
  end

  assign count = count_q;

  assert property (@(posedge clk) disable iff (reset) count_q <= PTRW'(FL));
  assert property (@(posedge clk) disable iff (reset) pop_cnt <= count_q);

endmodule

// File: rtl/rename_map_unit.sv
// Multi-lane register rename: speculative RAT, retirement RRAT, intra-group bypass,
// and single-cycle flush back to the committed mapping.
module rename_map_unit
  import rename_pkg::*;
#(
  parameter int ARCH_REGS = DEF_ARCH_REGS,
  parameter int PHYS_REGS = DEF_PHYS_REGS,
  parameter int WIDTH     = 2,
  parameter int CWIDTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  rename_map_unit_if.slave  bus
);
  localparam int AW = $clog2(ARCH_REGS);
  localparam int PW = $clog2(PHYS_REGS);
  localparam int CW = $clog2(PHYS_REGS - ARCH_REGS) + 1;

  logic [PW-1:0] rat_q  [ARCH_REGS];
  logic [PW-1:0] rrat_q [ARCH_REGS];
  logic [PW-1:0] rat_d  [ARCH_REGS];
  logic [PW-1:0] rrat_d [ARCH_REGS];

  logic [WIDTH-1:0]           lane_alloc;
  logic [WIDTH-1:0][PW-1:0]   pop_tags;
  logic [WIDTH-1:0][PW-1:0]   p_src1, p_src2, p_dest, p_old;
  logic [CWIDTH-1:0]          push_valid;
  logic [CWIDTH-1:0][PW-1:0]  push_tags;
  logic [CW-1:0]              pop_cnt;
  logic [CW-1:0]              count;
  logic                       fire;

  assign fire = bus.rename_ready && (|bus.rename_valid) && !bus.flush;

  // NOTE: every output of this block gets a default before the lane loop so no path
  // through it leaves a value held, which would infer a latch.
  always_comb begin : rename_lanes
    int slot;
    slot       = 0;
    lane_alloc = '0;
    p_src1     = '0;
    p_src2     = '0;
    p_dest     = '0;
    p_old      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lane_alloc[i] = bus.rename_valid[i] && (bus.rename_dest[i] != AW'(ZERO_REG));
      p_src1[i] = rat_q[bus.rename_src1[i]];
      p_src2[i] = rat_q[bus.rename_src2[i]];
      p_old[i]  = rat_q[bus.rename_dest[i]];
      // Ascending j so the youngest earlier writer of the same arch reg wins.
      for (int j = 0; j < i; j++) begin
        if (lane_alloc[j]) begin
          if (bus.rename_dest[j] == bus.rename_src1[i]) p_src1[i] = p_dest[j];
          if (bus.rename_dest[j] == bus.rename_src2[i]) p_src2[i] = p_dest[j];
          if (bus.rename_dest[j] == bus.rename_dest[i]) p_old[i]  = p_dest[j];
        end
      end
      if (bus.rename_src1[i] == AW'(ZERO_REG)) p_src1[i] = '0;
      if (bus.rename_src2[i] == AW'(ZERO_REG)) p_src2[i] = '0;
      if (lane_alloc[i]) begin
        for (int k = 0; k < WIDTH; k++) begin
          if (k == slot) p_dest[i] = pop_tags[k];
        end
        slot++;
      end
    end
    pop_cnt = fire ? CW'(slot) : '0;
  end

  // NOTE: rrat_d/rat_d are working copies updated with blocking assignments so later
  // commit lanes observe the mappings written by earlier lanes of the same cycle.
  always_comb begin : map_next
    rrat_d     = rrat_q;
    push_valid = '0;
    push_tags  = '0;
    for (int k = 0; k < CWIDTH; k++) begin
      if (bus.commit_valid[k] && (bus.commit_arch[k] != AW'(ZERO_REG))) begin
        push_valid[k]               = 1'b1;
        push_tags[k]                = rrat_d[bus.commit_arch[k]];
        rrat_d[bus.commit_arch[k]]  = bus.commit_phys[k];
      end
    end
    rat_d = rat_q;
    if (fire) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (lane_alloc[i]) rat_d[bus.rename_dest[i]] = p_dest[i];
      end
    end
    if (bus.flush) rat_d = rrat_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat_q[i]  <= PW'(i);
        rrat_q[i] <= PW'(i);
      end
    end else begin
      rat_q  <= rat_d;
      rrat_q <= rrat_d;
    end
  end

  rename_free_list #(
    .ARCH_REGS (ARCH_REGS),
    .PHYS_REGS (PHYS_REGS),
    .WIDTH     (WIDTH),
    .CWIDTH    (CWIDTH)
  ) u_free_list (
    .clk        (clk),
    .reset      (reset),
    .pop_cnt    (pop_cnt),
    .pop_tags   (pop_tags),
    .push_valid (push_valid),
    .push_tags  (push_tags),
    .flush      (bus.flush),
    .count      (count)
  );

  assign bus.rename_ready  = count >= CW'(WIDTH);
  assign bus.free_count    = count;
  assign bus.phys_src1     = p_src1;
  assign bus.phys_src2     = p_src2;
  assign bus.phys_dest     = p_dest;
  assign bus.phys_old_dest = p_old;

endmodule

// File: tb/tb_rename_map_unit.sv
// Randomized + directed bench for rename_map_unit against a queue-based renaming model.
module tb_rename_map_unit;
  localparam int NA = 32;
  localparam int NP = 64;
  localparam int W  = 2;
  localparam int CWD = 2;
  localparam int FL = NP - NA;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rename_map_unit_if #(.ARCH_REGS(NA), .PHYS_REGS(NP), .WIDTH(W), .CWIDTH(CWD)) bus ();

  rename_map_unit #(.ARCH_REGS(NA), .PHYS_REGS(NP), .WIDTH(W), .CWIDTH(CWD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic               rdy;
    logic [5:0]         cnt;
    logic [W-1:0]       chk;
    logic [W-1:0][5:0]  s1;
    logic [W-1:0][5:0]  s2;
    logic [W-1:0][5:0]  d;
    logic [W-1:0][5:0]  od;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: maps as arrays, free list and in-flight allocations as queues.
  int rat[NA];
  int rrat[NA];
  int fq[$];
  int ia[$];
  int ip[$];

  bit rv[W];
  int rs1[W], rs2[W], rd[W];
  bit cv[CWD];
  int ca[CWD], cp[CWD];
  bit fl;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < W; i++) begin
      rv[i] = 0; rs1[i] = 0; rs2[i] = 0; rd[i] = 0;
    end
    for (int k = 0; k < CWD; k++) begin
      cv[k] = 0; ca[k] = 0; cp[k] = 0;
    end
    fl = 0;
  endtask

  task automatic set_ren(int l, int a, int b, int d);
    rv[l] = 1; rs1[l] = a; rs2[l] = b; rd[l] = d;
  endtask

  task automatic set_com(int l, int a, int p);
    cv[l] = 1; ca[l] = a; cp[l] = p;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      rat[i] = i; rrat[i] = i;
    end
    fq.delete();
    for (int i = 0; i < FL; i++) fq.push_back(NA + i);
    ia.delete();
    ip.delete();
  endtask

  task automatic drive_idle();
    bus.rename_valid = '0; bus.rename_src1 = '0; bus.rename_src2 = '0; bus.rename_dest = '0;
    bus.commit_valid = '0; bus.commit_arch = '0; bus.commit_phys = '0; bus.flush = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    #1;
    check("reset_free_count", int'(bus.free_count), FL);
    check("reset_ready", int'(bus.rename_ready), 1);
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  // One clock of stimulus: drive, predict this cycle's outputs, advance the model.
  task automatic step();
    exp_t e;
    int rat_w[NA];
    int nalloc, pd;
    bit rdy, fire, anyv;
    @(negedge clk);
    for (int i = 0; i < W; i++) begin
      bus.rename_valid[i] = rv[i];
      bus.rename_src1[i]  = 5'(rs1[i]);
      bus.rename_src2[i]  = 5'(rs2[i]);
      bus.rename_dest[i]  = 5'(rd[i]);
    end
    for (int k = 0; k < CWD; k++) begin
      bus.commit_valid[k] = cv[k];
      bus.commit_arch[k]  = 5'(ca[k]);
      bus.commit_phys[k]  = 6'(cp[k]);
    end
    bus.flush = fl;

    e = '0;
    rdy = fq.size() >= W;
    e.rdy = rdy;
    e.cnt = 6'(fq.size());
    anyv = 0;
    for (int i = 0; i < W; i++) anyv |= rv[i];
    fire = rdy && anyv && !fl;
    rat_w = rat;
    nalloc = 0;
    for (int i = 0; i < W; i++) begin
      if (rv[i]) begin
        e.chk[i] = rdy;
        e.s1[i] = 6'((rs1[i] == 0) ? 0 : rat_w[rs1[i]]);
        e.s2[i] = 6'((rs2[i] == 0) ? 0 : rat_w[rs2[i]]);
        e.od[i] = 6'(rat_w[rd[i]]);
        pd = 0;
        if (rd[i] != 0) begin
          pd = (nalloc < fq.size()) ? fq[nalloc] : 0;
          nalloc++;
          rat_w[rd[i]] = pd;
          if (fire) begin
            ia.push_back(rd[i]);
            ip.push_back(pd);
          end
        end
        e.d[i] = 6'(pd);
      end
    end
    if (fire) begin
      rat = rat_w;
      repeat (nalloc) void'(fq.pop_front());
    end
    for (int k = 0; k < CWD; k++) begin
      if (cv[k] && ca[k] != 0) begin
        fq.push_back(rrat[ca[k]]);
        rrat[ca[k]] = cp[k];
        if (ia.size() > 0) begin
          void'(ia.pop_front());
          void'(ip.pop_front());
        end
      end
    end
    if (fl) begin
      int nq[$];
      rat = rrat;
      nq = ip;
      foreach (fq[i]) nq.push_back(fq[i]);
      fq = nq;
      ia.delete();
      ip.delete();
    end
    sb.push_back(e);
  endtask

  task automatic idle_step();
    clear_stim();
    step();
  endtask

  task automatic rand_step(int flush_pct);
    int avail, n, taken;
    clear_stim();
    for (int i = 0; i < W; i++) begin
      rv[i]  = ($urandom_range(0, 3) != 0);
      rs1[i] = $urandom_range(0, NA-1);
      rs2[i] = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, NA-1);
      rd[i]  = ($urandom_range(0, 5) == 0) ? 0 :
               ($urandom_range(0, 1) == 0) ? $urandom_range(1, 7) : $urandom_range(1, NA-1);
    end
    avail = ia.size();
    n = $urandom_range(0, (avail < CWD) ? avail : CWD);
    taken = 0;
    for (int k = 0; k < CWD; k++) begin
      if (k < n) begin
        if ($urandom_range(0, 9) == 0) set_com(k, 0, $urandom_range(0, NP-1));
        else begin
          set_com(k, ia[taken], ip[taken]);
          taken++;
        end
      end
    end
    fl = ($urandom_range(0, 99) < flush_pct);
    step();
  endtask

  // Monitor: compares whatever the DUT presents against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("free_count", int'(bus.free_count), int'(e.cnt));
        check("rename_ready", int'(bus.rename_ready), int'(e.rdy));
        for (int i = 0; i < W; i++) begin
          if (e.chk[i]) begin
            check($sformatf("phys_src1[%0d]", i), int'(bus.phys_src1[i]), int'(e.s1[i]));
            check($sformatf("phys_src2[%0d]", i), int'(bus.phys_src2[i]), int'(e.s2[i]));
            check($sformatf("phys_dest[%0d]", i), int'(bus.phys_dest[i]), int'(e.d[i]));
            check($sformatf("phys_old_dest[%0d]", i), int'(bus.phys_old_dest[i]), int'(e.od[i]));
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    drive_idle();
    clear_stim();
    model_reset();
    repeat (2) @(posedge clk);

    // Two-lane group with a RAW dependency through x5.
    do_reset();
    clear_stim(); set_ren(0, 5, 0, 5); set_ren(1, 5, 0, 7); step();
    idle_step();

    // x0 destination does not allocate; x0 source stays tag 0.
    do_reset();
    clear_stim(); set_ren(0, 1, 2, 0); set_ren(1, 3, 4, 3); step();
    clear_stim(); set_ren(0, 0, 0, 0); set_ren(1, 0, 3, 0); step();
    idle_step();

    // Drain the free list, then refill one tag at a time through commits.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      clear_stim();
      if (c == 0) begin
        set_ren(0, 1, 2, 5); set_ren(1, 3, 4, 7);
      end else begin
        set_ren(0, c, c + 1, 10 + (c % 8)); set_ren(1, c + 2, 5, 20 + (c % 4));
      end
      step();
    end
    idle_step();
    clear_stim(); set_com(0, ia[0], ip[0]); set_ren(0, 1, 1, 6); step();
    idle_step();
    clear_stim(); set_com(0, ia[0], ip[0]); step();
    clear_stim(); set_ren(0, 5, 7, 8); set_ren(1, 8, 6, 9); step();

    // Commit one of three, flush, and reallocate.
    do_reset();
    clear_stim(); set_ren(0, 1, 2, 5); set_ren(1, 3, 4, 7); step();
    clear_stim(); set_ren(0, 1, 2, 9); step();
    clear_stim(); set_com(0, 5, 32); step();
    clear_stim(); fl = 1; step();
    clear_stim(); set_ren(0, 5, 7, 1); set_ren(1, 9, 1, 2); step();
    idle_step();

    // Two same-cycle commits to one arch reg.
    do_reset();
    clear_stim(); set_ren(0, 4, 0, 4); set_ren(1, 4, 0, 4); step();
    clear_stim(); set_com(0, 4, 32); set_com(1, 4, 33); step();
    clear_stim(); fl = 1; step();
    clear_stim(); set_ren(0, 4, 4, 4); step();
    idle_step();

    // Reset mid-burst with ten free entries left.
    do_reset();
    for (int c = 0; c < 11; c++) begin
      clear_stim(); set_ren(0, c, 0, 1 + c); set_ren(1, 0, c, 12 + c); step();
    end
    idle_step();
    do_reset();
    clear_stim(); set_ren(0, 3, 0, 3); step();
    idle_step();

    // Random traffic with occasional flushes and resets.
    for (int r = 0; r < 3000; r++) begin
      if (r % 800 == 799) do_reset();
      rand_step(4);
    end

    @(negedge clk);
    #4;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
